// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and EX-resolution signal bundle for branch_predict_unit.
// The master side is the pipeline (drives PCs and resolved outcomes);
// the slave side is the predictor (returns predictions, redirect and stats).
interface branch_predict_unit_if #(
  parameter int PC_W = 9
);
  // Fetch-stage lookup
  logic [PC_W-1:0] if_pc;
  logic            pred_taken;
  logic [31:0]     pred_target;

  // EX-stage resolution
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic            ex_is_jump;
  logic            ex_taken;
  logic [31:0]     ex_target;
  logic            ex_pred_taken;
  logic [31:0]     ex_pred_target;
  logic            flush;

  // Outcome and statistics
  logic            mispredict;
  logic [31:0]     redirect_pc;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;

  modport master (
    output if_pc,
    output ex_valid,
    output ex_pc,
    output ex_is_jump,
    output ex_taken,
    output ex_target,
    output ex_pred_taken,
    output ex_pred_target,
    output flush,
    input  pred_taken,
    input  pred_target,
    input  mispredict,
    input  redirect_pc,
    input  stat_branches,
    input  stat_mispredicts
  );

  modport slave (
    input  if_pc,
    input  ex_valid,
    input  ex_pc,
    input  ex_is_jump,
    input  ex_taken,
    input  ex_target,
    input  ex_pred_taken,
    input  ex_pred_target,
    input  flush,
    output pred_taken,
    output pred_target,
    output mispredict,
    output redirect_pc,
    output stat_branches,
    output stat_mispredicts
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Fetch lookup is purely combinational against the registered table, so a
// same-cycle update to the looked-up index is only seen on the next cycle.
// EX resolution trains the table and raises mispredict / redirect_pc.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input logic                 clk,
  input logic                 reset,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ZERO = '0;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_ONE << (CTR_W - 1);
  localparam logic [31:0]      STAT_MAX = '1;

  // Parameter sanity: the tag must keep at least one bit, the table must be
  // a power of two, and the counter width must stay in its supported range.
  if (IDX_W + 2 >= PC_W) begin : g_bad_pc_w
    $error("branch_predict_unit: PC_W too small for ENTRIES (no tag bits left)");
  end
  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("branch_predict_unit: ENTRIES must be a power of two >= 2");
  end
  if (CTR_W < 1 || CTR_W > 4) begin : g_bad_ctr_w
    $error("branch_predict_unit: CTR_W must be in 1..4");
  end

  // Table storage
  logic             entry_valid  [ENTRIES];
  logic [TAG_W-1:0] entry_tag    [ENTRIES];
  logic [31:0]      entry_target [ENTRIES];
  logic [CTR_W-1:0] entry_ctr    [ENTRIES];

  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  // Fetch lookup
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;

  assign look_idx = bus.if_pc[IDX_W+1:2];
  assign look_tag = bus.if_pc[PC_W-1:IDX_W+2];
  assign look_hit = entry_valid[look_idx] && (entry_tag[look_idx] == look_tag);

  assign bus.pred_taken  = look_hit && entry_ctr[look_idx][CTR_W-1];
  assign bus.pred_target = bus.pred_taken ? entry_target[look_idx]
                                          : 32'(bus.if_pc) + 32'd4;

  // EX resolution
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CTR_W-1:0] ctr_next;
  logic [CTR_W-1:0] ctr_alloc;

  assign upd_idx = bus.ex_pc[IDX_W+1:2];
  assign upd_tag = bus.ex_pc[PC_W-1:IDX_W+2];
  assign upd_hit = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);

  assign bus.mispredict = bus.ex_valid &&
                          ((bus.ex_taken != bus.ex_pred_taken) ||
                           (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

  assign bus.redirect_pc = bus.ex_taken ? bus.ex_target
                                        : 32'(bus.ex_pc) + 32'd4;

  // Freshly allocated jumps start strongly taken, branches weakly taken.
  assign ctr_alloc = bus.ex_is_jump ? CTR_MAX : CTR_WEAK;

  // Low PC bits select a byte within an instruction word and never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

  // Next counter value for a hit: jumps pin to all-ones, branches saturate up/down.
  always_comb begin
    ctr_next = entry_ctr[upd_idx];
    if (bus.ex_is_jump) begin
      ctr_next = CTR_MAX;
    end else if (bus.ex_taken) begin
      if (entry_ctr[upd_idx] != CTR_MAX) begin
        ctr_next = entry_ctr[upd_idx] + CTR_ONE;
      end
    end else begin
      if (entry_ctr[upd_idx] != CTR_ZERO) begin
        ctr_next = entry_ctr[upd_idx] - CTR_ONE;
      end
    end
  end

  // Table training; flush drops every valid bit and overrides any update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_valid[i]  <= 1'b0;
        entry_tag[i]    <= '0;
        entry_target[i] <= '0;
        entry_ctr[i]    <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_valid[i] <= 1'b0;
      end
    end else if (bus.ex_valid) begin
      if (upd_hit) begin
        entry_ctr[upd_idx] <= ctr_next;
        if (bus.ex_taken) begin
          entry_target[upd_idx] <= bus.ex_target;
        end
      end else if (bus.ex_taken) begin
        entry_valid[upd_idx]  <= 1'b1;
        entry_tag[upd_idx]    <= upd_tag;
        entry_target[upd_idx] <= bus.ex_target;
        entry_ctr[upd_idx]    <= ctr_alloc;
      end
    end
  end

  // Saturating performance counters; they keep counting through a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (bus.ex_valid && (stat_branches_q != STAT_MAX)) begin
        stat_branches_q <= stat_branches_q + 32'd1;
      end
      if (bus.mispredict && (stat_mispredicts_q != STAT_MAX)) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by
// randomized traffic, all compared against a table-level behavioural model.
module tb_branch_predict_unit;

  localparam int PC_W    = 9;
  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int CTR_TOP = (1 << CTR_W) - 1;
  localparam int CTR_HALF = 1 << (CTR_W - 1);
  localparam longint STAT_CAP = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset;

  // Free-running clock
  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_W(PC_W)) bus ();

  branch_predict_unit #(
    .PC_W   (PC_W),
    .ENTRIES(ENTRIES),
    .CTR_W  (CTR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one record per BTB slot plus the two statistics
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  longint      m_branches;
  longint      m_mispredicts;

  function automatic int idx_of(input int unsigned pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = '0;
      m_ctr[i]    = 0;
    end
    m_branches    = 0;
    m_mispredicts = 0;
  endtask

  task automatic model_lookup(input int unsigned pc, output bit taken, output logic [31:0] target);
    int i;
    i      = idx_of(pc);
    taken  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= CTR_HALF);
    target = taken ? m_target[i] : 32'(pc + 4);
  endtask

  function automatic bit model_mispredict();
    return bus.ex_valid && ((bus.ex_taken != bus.ex_pred_taken) ||
                            (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
  endfunction

  task automatic model_edge();
    bit mp;
    int i;
    bit hit;
    mp = model_mispredict();
    if (bus.ex_valid && m_branches < STAT_CAP) m_branches++;
    if (mp && m_mispredicts < STAT_CAP) m_mispredicts++;
    if (bus.flush) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (bus.ex_valid) begin
      i   = idx_of(int'(bus.ex_pc));
      hit = m_valid[i] && (m_tag[i] == tag_of(int'(bus.ex_pc)));
      if (hit) begin
        if (bus.ex_is_jump)     m_ctr[i] = CTR_TOP;
        else if (bus.ex_taken)  m_ctr[i] = (m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP;
        else                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        if (bus.ex_taken) m_target[i] = bus.ex_target;
      end else if (bus.ex_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(int'(bus.ex_pc));
        m_target[i] = bus.ex_target;
        m_ctr[i]    = bus.ex_is_jump ? CTR_TOP : CTR_HALF;
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, then check the combinational outputs against the model
  task automatic apply_stimulus(input logic [PC_W-1:0] if_pc, input bit ex_valid,
                                input logic [PC_W-1:0] ex_pc, input bit is_jump,
                                input bit taken, input logic [31:0] target,
                                input bit pred_taken, input logic [31:0] pred_target,
                                input bit flush);
    bit          e_taken;
    logic [31:0] e_target;
    logic [31:0] e_redirect;
    bus.if_pc          = if_pc;
    bus.ex_valid       = ex_valid;
    bus.ex_pc          = ex_pc;
    bus.ex_is_jump     = is_jump;
    bus.ex_taken       = taken;
    bus.ex_target      = target;
    bus.ex_pred_taken  = pred_taken;
    bus.ex_pred_target = pred_target;
    bus.flush          = flush;
    #1;
    model_lookup(int'(if_pc), e_taken, e_target);
    e_redirect = taken ? target : 32'(int'(ex_pc) + 4);
    check_output("pred_taken", 32'(bus.pred_taken), 32'(e_taken));
    check_output("pred_target", bus.pred_target, e_target);
    check_output("mispredict", 32'(bus.mispredict), 32'(model_mispredict()));
    check_output("redirect_pc", bus.redirect_pc, e_redirect);
  endtask

  // Clock the cycle in, advance the model, then check the statistics
  task automatic end_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_output("stat_branches", bus.stat_branches, 32'(m_branches));
    check_output("stat_mispredicts", bus.stat_mispredicts, 32'(m_mispredicts));
  endtask

  task automatic idle_lookup(input logic [PC_W-1:0] pc);
    apply_stimulus(pc, 1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  logic [PC_W-1:0] r_if_pc;
  logic [PC_W-1:0] r_ex_pc;
  bit              r_jump;
  bit              r_taken;
  logic [31:0]     r_target;
  bit              r_pt;
  logic [31:0]     r_ptgt;

  initial begin
    reset = 1'b1;
    model_reset();
    bus.if_pc = 9'h010; bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_is_jump = 1'b0;
    bus.ex_taken = 1'b0; bus.ex_target = '0; bus.ex_pred_taken = 1'b0;
    bus.ex_pred_target = '0; bus.flush = 1'b0;
    #2;
    check_output("reset_pred_taken", 32'(bus.pred_taken), 32'h0);
    check_output("reset_pred_target", bus.pred_target, 32'h014);
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Cold lookup after reset
    idle_lookup(9'h010);
    check_output("cold_pred_taken", 32'(bus.pred_taken), 32'h0);
    check_output("cold_pred_target", bus.pred_target, 32'h014);
    end_cycle();
    check_output("cold_stat_branches", bus.stat_branches, 32'h0);

    // Taken branch that was predicted not taken
    apply_stimulus(9'h010, 1'b1, 9'h010, 1'b0, 1'b1, 32'h040, 1'b0, 32'h014, 1'b0);
    check_output("first_mispredict", 32'(bus.mispredict), 32'h1);
    check_output("first_redirect", bus.redirect_pc, 32'h040);
    end_cycle();
    idle_lookup(9'h010);
    check_output("trained_pred_taken", 32'(bus.pred_taken), 32'h1);
    check_output("trained_pred_target", bus.pred_target, 32'h040);
    check_output("trained_stat_mispredicts", bus.stat_mispredicts, 32'h1);
    end_cycle();

    // Same branch resolved not taken twice: counter walks down
    apply_stimulus(9'h010, 1'b1, 9'h010, 1'b0, 1'b0, 32'h0, 1'b1, 32'h040, 1'b0);
    end_cycle();
    apply_stimulus(9'h010, 1'b1, 9'h010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h014, 1'b0);
    check_output("weak_nt_pred_taken", 32'(bus.pred_taken), 32'h0);
    check_output("nt_mispredict", 32'(bus.mispredict), 32'h0);
    check_output("nt_redirect", bus.redirect_pc, 32'h014);
    end_cycle();

    // Aliasing: 0x010 and 0x050 share an index
    apply_stimulus(9'h010, 1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    end_cycle();
    apply_stimulus(9'h010, 1'b1, 9'h010, 1'b0, 1'b1, 32'h100, 1'b0, 32'h014, 1'b0);
    end_cycle();
    apply_stimulus(9'h050, 1'b1, 9'h050, 1'b0, 1'b1, 32'h200, 1'b0, 32'h054, 1'b0);
    end_cycle();
    idle_lookup(9'h010);
    check_output("alias_old_miss", 32'(bus.pred_taken), 32'h0);
    idle_lookup(9'h050);
    check_output("alias_new_hit", 32'(bus.pred_taken), 32'h1);
    check_output("alias_new_target", bus.pred_target, 32'h200);
    end_cycle();

    // Flush beats a simultaneous taken update, stats still count
    apply_stimulus(9'h050, 1'b1, 9'h090, 1'b1, 1'b1, 32'h300, 1'b0, 32'h094, 1'b1);
    end_cycle();
    idle_lookup(9'h050);
    check_output("flush_miss_050", 32'(bus.pred_taken), 32'h0);
    idle_lookup(9'h090);
    check_output("flush_miss_090", 32'(bus.pred_taken), 32'h0);
    end_cycle();

    // Randomized traffic over a small PC pool (indices 0..3) to force hits and aliasing
    for (int n = 0; n < 400; n++) begin
      bit          pt_model;
      logic [31:0] ptgt_model;
      r_ex_pc  = PC_W'($urandom_range(0, 511)) & 9'h1CF;
      r_if_pc  = ($urandom_range(0, 9) < 3) ? r_ex_pc : (PC_W'($urandom_range(0, 511)) & 9'h1CF);
      r_jump   = ($urandom_range(0, 4) == 0);
      r_taken  = r_jump ? 1'b1 : ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 2))
        0:       r_target = 32'h040;
        1:       r_target = 32'h080;
        default: r_target = $urandom;
      endcase
      model_lookup(int'(r_ex_pc), pt_model, ptgt_model);
      if ($urandom_range(0, 3) != 0) begin
        r_pt   = pt_model;
        r_ptgt = ptgt_model;
      end else begin
        r_pt   = $urandom_range(0, 1) == 1;
        r_ptgt = $urandom_range(0, 1) == 1 ? r_target : $urandom;
      end
      apply_stimulus(r_if_pc, ($urandom_range(0, 4) != 0), r_ex_pc, r_jump, r_taken,
                     r_target, r_pt, r_ptgt, ($urandom_range(0, 31) == 0));
      end_cycle();
    end

    // Reset arriving mid-cycle discards the pending update
    apply_stimulus(9'h0C4, 1'b1, 9'h0C4, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0C8, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_output("async_reset_pred_taken", 32'(bus.pred_taken), 32'h0);
    check_output("async_reset_pred_target", bus.pred_target, 32'h0C8);
    check_output("async_reset_stat_branches", bus.stat_branches, 32'h0);
    check_output("async_reset_stat_mispredicts", bus.stat_mispredicts, 32'h0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_output("post_reset_still_miss", 32'(bus.pred_taken), 32'h0);
    end_cycle();
    idle_lookup(9'h0C4);
    check_output("post_reset_update_hit", 32'(bus.pred_taken), 32'h1);
    check_output("post_reset_update_target", bus.pred_target, 32'h300);
    end_cycle();

    // Statistics saturation: jump both counters near the top, then keep mispredicting
    force dut.stat_branches_q    = 32'hFFFF_FFFE;
    force dut.stat_mispredicts_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_branches_q;
    release dut.stat_mispredicts_q;
    m_branches    = 64'h0000_0000_FFFF_FFFE;
    m_mispredicts = 64'h0000_0000_FFFF_FFFE;
    for (int n = 0; n < 3; n++) begin
      apply_stimulus(9'h104, 1'b1, 9'h104, 1'b0, 1'b1, 32'h1234, 1'b0, 32'h108, 1'b0);
      end_cycle();
    end
    check_output("sat_stat_branches", bus.stat_branches, 32'hFFFF_FFFF);
    check_output("sat_stat_mispredicts", bus.stat_mispredicts, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 9, giving the PC width in bits.
REQ-002 The block SHALL have parameter ENTRIES, default 16, giving the number of BTB entries; it is a power of two, at least 2.
REQ-003 The block SHALL have parameter CTR_W, default 2, giving the saturating-counter width, range 1..4.
REQ-004 The block SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 Port if_pc, input, PC_W bits: fetch-stage PC to look up.
REQ-008 Port pred_taken, output, 1 bit: predicted taken for if_pc.
REQ-009 Port pred_target, output, 32 bits: predicted target for if_pc.
REQ-010 Port ex_valid, input, 1 bit: a resolved control transfer is present in EX.
REQ-011 Port ex_pc, input, PC_W bits: PC of the resolved instruction.
REQ-012 Port ex_is_jump, input, 1 bit: 1 = JAL/JALR, 0 = conditional branch.
REQ-013 Port ex_taken, input, 1 bit: actual outcome.
REQ-014 Port ex_target, input, 32 bits: actual target.
REQ-015 Port ex_pred_taken, input, 1 bit: prediction carried down the pipe.
REQ-016 Port ex_pred_target, input, 32 bits: predicted target carried down the pipe.
REQ-017 Port flush, input, 1 bit: invalidate all entries.
REQ-018 Port mispredict, output, 1 bit: EX outcome differs from prediction.
REQ-019 Port redirect_pc, output, 32 bits: correct next PC on a mispredict.
REQ-020 Port stat_branches, output, 32 bits: resolved-transfer count.
REQ-021 Port stat_mispredicts, output, 32 bits: mispredict count.

Function
REQ-022 The index SHALL be pc[IDX_W+1:2] with IDX_W = log2(ENTRIES), and the tag SHALL be pc[PC_W-1:IDX_W+2]; elaboration SHALL fail if IDX_W+2 >= PC_W.
REQ-023 Each entry SHALL hold: valid, tag, a 32-bit target, and a CTR_W-bit counter.
REQ-024 The lookup SHALL be combinational: pred_taken = valid && tag match && counter MSB; pred_target = the entry target when pred_taken, else {zero-extended if_pc}+4.
REQ-025 mispredict SHALL be combinational: ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
REQ-026 redirect_pc SHALL be ex_target if ex_taken, else zero-extended ex_pc+4, with 32-bit wrap.
REQ-027 All state updates SHALL occur on the rising clk edge only when ex_valid=1.
REQ-028 Hit (valid && tag match): taken -> counter incremented, saturating at all-ones, and target overwritten with ex_target; not taken -> counter decremented, saturating at 0, target kept.
REQ-029 Miss and taken: the entry SHALL be allocated or replaced with valid=1, the new tag, target=ex_target, and counter = weak-taken (MSB 1, rest 0) for a branch or all-ones for a jump.
REQ-030 Miss and not taken: no BTB write.
REQ-031 A jump hit SHALL force the counter to all-ones.
REQ-032 A lookup and an update to the same index in one cycle: the lookup SHALL return the pre-update contents, with the new contents visible next cycle.
REQ-033 flush SHALL clear all valid bits at the next edge, and flush SHALL win over a simultaneous update; targets, counters and stats are untouched.
REQ-034 stat_branches SHALL increment when ex_valid=1, stat_mispredicts SHALL increment when mispredict=1, and both SHALL saturate at 0xFFFFFFFF.

Reset
REQ-035 On reset assertion, immediately and independent of clk, all valid bits, counters and targets SHALL be 0 and both stats SHALL be 0, so pred_taken=0 and pred_target=if_pc+4.
REQ-036 Reset asserted mid-update SHALL discard the update, and the first update SHALL apply at the first rising edge after deassertion.

Verification
REQ-037 Reset, then if_pc=0x010 -> pred_taken=0, pred_target=0x014, stats=0.
REQ-038 Branch at ex_pc=0x010, taken to 0x040, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x040; next cycle if_pc=0x010 gives pred_taken=1, target 0x040, stat_mispredicts=1.
REQ-039 The same branch resolved not-taken twice (CTR_W=2): the counter goes 10->01->00; after the first, pred_taken=0, and the second gives mispredict=0 when ex_pred_taken=0, redirect_pc=0x014.
REQ-040 Aliasing (ENTRIES=16): a taken branch at 0x010, then a taken branch at 0x050 (same index, new tag) -> 0x010 misses and 0x050 hits.
REQ-041 flush and taken update in the same cycle -> all lookups miss next cycle, stat_branches still increments.
REQ-042 Preload stats to 0xFFFFFFFF via a long run -> further mispredicts leave both stats at 0xFFFFFFFF.
